// File: rtl/csa42_acc_if.sv
// Operand/result handshake bundle for the carry-save accumulator.
interface csa42_acc_if #(
    parameter int W     = 16,
    parameter int ACC_W = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, busy
    );
endinterface

// File: rtl/csa42_acc.sv
// Carry-save accumulator: a row of 4:2 compressors per beat, then a segmented multi-cycle CPA.
// Define AP_LSB_EN to swap the low AP_K columns for the cheap approximate cell.
module csa42_com #(
    parameter bit APPROX = 1'b0
) (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic cin,
    output logic sum,
    output logic carry,
    output logic cout
);
    logic s1;

    if (APPROX) begin : g_apx
        assign s1    = 1'b0;
        assign sum   = a | b | c | d;
        assign carry = (a & b) | (c & d);
        assign cout  = 1'b0;
    end else begin : g_exact
        // Two chained full adders: a+b+c+d+cin == sum + 2*(carry+cout)
        assign s1    = a ^ b ^ c;
        assign cout  = (a & b) | (a & c) | (b & c);
        assign sum   = s1 ^ d ^ cin;
        assign carry = (s1 & d) | (s1 & cin) | (d & cin);
    end
endmodule

module csa42_acc #(
    parameter int W       = 16,
    parameter int ACC_W   = 24,
    parameter int CPA_SEG = 8,
    parameter int AP_K    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    csa42_acc_if.slave  bus
);
    localparam int NSEG   = (ACC_W + CPA_SEG - 1) / CPA_SEG;
    localparam int PAD_W  = NSEG * CPA_SEG;
    localparam int LAST_W = ACC_W - (NSEG - 1) * CPA_SEG;
    localparam int SEG_W  = $clog2(NSEG + 1);
    localparam int SR_W   = CPA_SEG + 1;
`ifdef AP_LSB_EN
    localparam bit AP_EN = 1'b1;
`else
    localparam bit AP_EN = 1'b0;
`endif
    localparam int AP_COLS = AP_EN ? AP_K : 0;

    typedef enum logic [1:0] {S_ACC, S_RES, S_DONE} state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   s_q, c_q;
    logic               ovf_q;
    logic [SEG_W-1:0]   seg_q;
    logic               cpa_c_q;
    logic               in_ready_q, busy_q, out_valid_q, out_ovf_q;
    logic [ACC_W-1:0]   out_sum_q;

    logic [ACC_W-1:0]   a_ext, b_ext, sum, carry, cout, cin;
    logic [ACC_W-1:0]   s_d, c_d, out_sum_d;
    logic               drop;

    assign a_ext = ACC_W'(bus.in_a);
    assign b_ext = ACC_W'(bus.in_b);

    for (genvar i = 0; i < ACC_W; i++) begin : g_col
        if (i == 0 || i == AP_COLS) begin : g_cin0
            assign cin[i] = 1'b0;
        end else begin : g_cin
            assign cin[i] = cout[i-1];
        end
        csa42_com #(.APPROX(i < AP_COLS)) u_com (
            .a     (s_q[i]),
            .b     (c_q[i]),
            .c     (a_ext[i]),
            .d     (b_ext[i]),
            .cin   (cin[i]),
            .sum   (sum[i]),
            .carry (carry[i]),
            .cout  (cout[i])
        );
    end

    // Carries shift up one column; anything leaving the top column is overflow.
    assign s_d  = sum;
    assign c_d  = {carry[ACC_W-2:0], 1'b0};
    assign drop = carry[ACC_W-1] | cout[ACC_W-1];

    int               base;
    logic [CPA_SEG-1:0] seg_a, seg_b;
    logic [SR_W-1:0]  seg_res;
    logic             seg_co;
    logic [PAD_W-1:0] seg_mask;

    // One CPA segment per cycle, working in a zero-padded space so the tail segment needs no special slicing.
    always_comb begin
        base      = int'(seg_q) * CPA_SEG;
        seg_a     = CPA_SEG'(PAD_W'(s_q) >> base);
        seg_b     = CPA_SEG'(PAD_W'(c_q) >> base);
        seg_res   = {1'b0, seg_a} + {1'b0, seg_b} + SR_W'(cpa_c_q);
        seg_co    = (seg_q == SEG_W'(NSEG - 1)) ? seg_res[LAST_W] : seg_res[CPA_SEG];
        seg_mask  = PAD_W'({CPA_SEG{1'b1}}) << base;
        out_sum_d = ACC_W'((PAD_W'(out_sum_q) & ~seg_mask)
                         | (PAD_W'(seg_res[CPA_SEG-1:0]) << base));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_ACC;
            s_q         <= '0;
            c_q         <= '0;
            ovf_q       <= 1'b0;
            seg_q       <= '0;
            cpa_c_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_ACC: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        s_q   <= s_d;
                        c_q   <= c_d;
                        ovf_q <= ovf_q | drop;
                        if (bus.in_last) begin
                            state_q    <= S_RES;
                            seg_q      <= '0;
                            cpa_c_q    <= 1'b0;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                S_RES: begin
                    if (seg_q < SEG_W'(NSEG)) begin
                        out_sum_q <= out_sum_d;
                        cpa_c_q   <= seg_co;
                        seg_q     <= seg_q + 1'b1;
                        if (seg_q == SEG_W'(NSEG - 1)) ovf_q <= ovf_q | seg_co;
                    end else begin
                        // All segments resolved: publish the sticky overflow with the result.
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        out_ovf_q   <= ovf_q;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= S_ACC;
                        s_q         <= '0;
                        c_q         <= '0;
                        ovf_q       <= 1'b0;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= S_ACC;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_csa42_acc.sv
// Directed bench for csa42_acc: reset, latency, overflow, backpressure, mid-resolve reset, approx LSBs.
module tb_csa42_acc;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    csa42_acc_if #(.W(16), .ACC_W(24)) bus ();

    csa42_acc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
        int k = 0;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) chk("send_ready_wait", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [23:0] exp_sum, input logic exp_ovf);
        int k = 0;
        while (!bus.out_valid && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_latency"}, 32'(k), 32'd4);
        chk({tag, "_sum"}, 32'(bus.out_sum), 32'(exp_sum));
        chk({tag, "_ovf"}, 32'(bus.out_ovf), 32'(exp_ovf));
    endtask

    initial begin
        bit seen;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        // 1: reset
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
        chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);

        // 2: single beat 3+5
        send(16'h0003, 16'h0005, 1'b1);
        chk("single_busy", 32'(bus.busy), 32'd1);
        chk("single_in_ready", 32'(bus.in_ready), 32'd0);
        wait_result("single", 24'h000008, 1'b0);
        tick();
        chk("single_consumed", 32'(bus.out_valid), 32'd0);

        // multi-beat: 0x1234+0x4321 + 0xFFFF+0x0001 + 0x8000+0x8000 = 0x25555
        send(16'h1234, 16'h4321, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0);
        send(16'h8000, 16'h8000, 1'b1);
        wait_result("multi", 24'h025555, 1'b0);
        tick();

        // 3: 256 x (0xFFFF+0xFFFF) = 0x1FFFE00 -> wraps to 0xFFFE00 with overflow
        for (int i = 0; i < 256; i++) send(16'hFFFF, 16'hFFFF, i == 255);
        wait_result("ovf256", 24'hFFFE00, 1'b1);
        tick();

        // 4: backpressure holds the result; beats offered meanwhile are ignored
        bus.out_ready = 1'b0;
        send(16'h0003, 16'h0005, 1'b1);
        wait_result("bp", 24'h000008, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_a     = 16'h0100;
        bus.in_b     = 16'h0100;
        for (int i = 0; i < 10; i++) tick();
        chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_hold_sum", 32'(bus.out_sum), 32'h8);
        chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_hold_busy", 32'(bus.busy), 32'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        send(16'h0001, 16'h0002, 1'b1);
        wait_result("bp_next", 24'h000003, 1'b0);
        tick();

        // 5: reset during RESOLVE discards the partial result
        send(16'h0007, 16'h0009, 1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_sum", 32'(bus.out_sum), 32'd0);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen |= bus.out_valid;
        end
        chk("midrst_no_valid", 32'(seen), 32'd0);
        send(16'h0001, 16'h0001, 1'b1);
        wait_result("midrst_next", 24'h000002, 1'b0);
        tick();

        // 6: low columns, exact vs approximate
        send(16'h000F, 16'h0001, 1'b1);
`ifdef AP_LSB_EN
        wait_result("lsb", 24'h000011, 1'b0);
`else
        wait_result("lsb", 24'h000010, 1'b0);
`endif
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
